// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-address sequencer.
// Holds default widths, the next-PC source encoding and the target alignment helper.
package pc_pkg;

    localparam int unsigned DEFAULT_XLEN         = 32;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0040_0000;
    localparam int unsigned MAX_XLEN             = 64;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_HOLD,
        SRC_RAS,
        SRC_REDIRECT,
        SRC_TRAP
    } next_pc_src_t;

    // Clears the byte-offset bits below the instruction size; ilen_bytes is a power of two.
    function automatic logic [MAX_XLEN-1:0] align_pc(input logic [MAX_XLEN-1:0] addr,
                                                     input int unsigned         ilen_bytes);
        logic [MAX_XLEN-1:0] mask;
        mask = MAX_XLEN'(ilen_bytes - 1);
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack with saturating occupancy count.
// Arbitrates push, pop and flush; the top entry is exposed combinationally.
module return_stack
    import pc_pkg::*;
#(
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned XLEN      = DEFAULT_XLEN,
    localparam int unsigned PTR_W    = $clog2(RAS_DEPTH),
    localparam int unsigned CNT_W    = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [XLEN-1:0]  push_addr_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [XLEN-1:0]  top_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_m1, wr_idx;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_en;
    logic             pop_ok;

    // ptr_q is the next write slot; the top lives one below, wrapping naturally.
    assign ptr_m1  = ptr_q - PTR_W'(1);
    assign top_o   = mem_q[ptr_m1];
    assign count_o = cnt_q;
    assign pop_ok  = pop_i && (cnt_q != '0);

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (flush_i) begin
            cnt_d = '0;
            if (push_i) begin
                wr_en = 1'b1;
                ptr_d = ptr_q + PTR_W'(1);
                cnt_d = CNT_W'(1);
            end
        end else if (push_i && pop_ok) begin
            // Pop then push: the old top is consumed and replaced in place.
            wr_en  = 1'b1;
            wr_idx = ptr_m1;
        end else if (push_i) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + PTR_W'(1);
            cnt_d = (cnt_q == FULL) ? cnt_q : cnt_q + CNT_W'(1);
        end else if (pop_ok) begin
            ptr_d = ptr_m1;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // NOTE: storage has no reset; a zero count already marks every entry invalid.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_idx] <= push_addr_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next fetch-PC generator at the head of IF: trap > redirect > RAS return > stall > sequential.
// Owns the PC register and misalignment pulse; the return stack lives in a sub-module.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter int unsigned     ILEN_BYTES   = 4,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         trap_valid,
    input  logic [XLEN-1:0]              trap_vector,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_addr,
    input  logic                         call_valid,
    input  logic [XLEN-1:0]              call_ret_addr,
    input  logic                         ret_valid,
    output logic [XLEN-1:0]              fetch_pc,
    output logic                         fetch_valid,
    output logic                         misaligned,
    output logic [$clog2(RAS_DEPTH):0]   ras_count
);

    localparam int unsigned     CNT_W    = $clog2(RAS_DEPTH) + 1;
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(ILEN_BYTES - 1);
    localparam logic [XLEN-1:0] INC      = XLEN'(ILEN_BYTES);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic             valid_q;
    logic             mis_q, mis_d;
    logic [XLEN-1:0]  ras_top;
    logic [CNT_W-1:0] ras_cnt;
    next_pc_src_t     src;

    return_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .XLEN      (XLEN)
    ) u_ras (
        .clock       (clock),
        .reset       (reset),
        .push_i      (call_valid),
        .push_addr_i (call_ret_addr),
        .pop_i       (ret_valid),
        .flush_i     (trap_valid),
        .top_o       (ras_top),
        .count_o     (ras_cnt)
    );

    // The first edge after reset only raises fetch_valid; RESET_VECTOR is fetched as-is.
    always_comb begin
        src = SRC_SEQ;
        if (!valid_q)                           src = SRC_HOLD;
        else if (trap_valid)                    src = SRC_TRAP;
        else if (redirect_valid)                src = SRC_REDIRECT;
        else if (ret_valid && ras_cnt != '0)    src = SRC_RAS;
        else if (stall)                         src = SRC_HOLD;
    end

    always_comb begin
        pc_d  = pc_q + INC;
        mis_d = 1'b0;
        unique case (src)
            SRC_TRAP: begin
                pc_d  = XLEN'(align_pc(MAX_XLEN'(trap_vector), ILEN_BYTES));
                mis_d = |(trap_vector & LOW_MASK);
            end
            SRC_REDIRECT: begin
                pc_d  = XLEN'(align_pc(MAX_XLEN'(redirect_addr), ILEN_BYTES));
                mis_d = |(redirect_addr & LOW_MASK);
            end
            SRC_RAS:  pc_d = ras_top;
            SRC_HOLD: pc_d = pc_q;
            SRC_SEQ:  pc_d = pc_q + INC;
            default:  pc_d = pc_q + INC;
        endcase
    end

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_VECTOR;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= 1'b1;
            mis_q   <= mis_d;
        end
    end

    assign fetch_pc    = pc_q;
    assign fetch_valid = valid_q;
    assign misaligned  = mis_q;
    assign ras_count   = ras_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues expected PC/misaligned/count,
// a negedge monitor pops and compares whenever fetch_valid is high.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0040_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_vector = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        call_valid = 1'b0;
    logic [31:0] call_ret_addr = '0;
    logic        ret_valid = 1'b0;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        misaligned;
    logic [2:0]  ras_count;

    typedef struct packed {
        logic [31:0] pc;
        logic        mis;
        logic [2:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    pc_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .trap_valid     (trap_valid),
        .trap_vector    (trap_vector),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .call_valid     (call_valid),
        .call_ret_addr  (call_ret_addr),
        .ret_valid      (ret_valid),
        .fetch_pc       (fetch_pc),
        .fetch_valid    (fetch_valid),
        .misaligned     (misaligned),
        .ras_count      (ras_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the state expected after the next edge.
    task automatic step(input logic tv, input logic [31:0] tvec,
                        input logic rv, input logic [31:0] raddr,
                        input logic cv, input logic [31:0] caddr,
                        input logic ret, input logic st,
                        input logic [31:0] e_pc, input logic e_mis, input logic [2:0] e_cnt);
        @(posedge clock);
        #1;
        trap_valid = tv;  trap_vector = tvec;
        redirect_valid = rv; redirect_addr = raddr;
        call_valid = cv;  call_ret_addr = caddr;
        ret_valid = ret;  stall = st;
        exp_q.push_back('{pc: e_pc, mis: e_mis, cnt: e_cnt});
    endtask

    always @(negedge clock) begin
        if (reset && fetch_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'(fetch_pc), 64'hDEAD_0000_0000_0000);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("fetch_pc", 64'(fetch_pc), 64'(e.pc));
                check("misaligned", 64'(misaligned), 64'(e.mis));
                check("ras_count", 64'(ras_count), 64'(e.cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        #23;
        check("rst_fetch_pc", 64'(fetch_pc), 64'(RV));
        check("rst_fetch_valid", 64'(fetch_valid), 64'd0);
        check("rst_misaligned", 64'(misaligned), 64'd0);
        check("rst_ras_count", 64'(ras_count), 64'd0);

        @(posedge clock); #1;
        reset = 1'b1;
        exp_q.push_back('{pc: RV, mis: 1'b0, cnt: 3'd0});
        step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0004, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0008, 0, 0);

        // Fill the RAS, then trap and redirect together: trap wins and flushes.
        step(0, 0, 0, 0, 1, 32'h1111_0000, 0, 0, 32'h0040_000C, 0, 1);
        step(0, 0, 0, 0, 1, 32'h1111_0010, 0, 0, 32'h0040_0010, 0, 2);
        step(1, 32'h8000_0000, 1, 32'h0040_0100, 0, 0, 0, 0, 32'h8000_0000, 0, 0);

        // Misaligned redirect and trap targets are corrected and flagged for one cycle.
        step(0, 0, 1, 32'h0040_0102, 0, 0, 0, 0, 32'h0040_0100, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0104, 0, 0);
        step(1, 32'h8000_0006, 0, 0, 0, 0, 0, 0, 32'h8000_0004, 1, 0);
        step(0, 0, 1, 32'h0040_0200, 0, 0, 0, 0, 32'h0040_0200, 0, 0);

        // Five pushes into a 4-deep stack, then five returns.
        step(0, 0, 0, 0, 1, 32'h0050_0000, 0, 0, 32'h0040_0204, 0, 1);
        step(0, 0, 0, 0, 1, 32'h0050_0010, 0, 0, 32'h0040_0208, 0, 2);
        step(0, 0, 0, 0, 1, 32'h0050_0020, 0, 0, 32'h0040_020C, 0, 3);
        step(0, 0, 0, 0, 1, 32'h0050_0030, 0, 0, 32'h0040_0210, 0, 4);
        step(0, 0, 0, 0, 1, 32'h0050_0040, 0, 0, 32'h0040_0214, 0, 4);
        step(0, 0, 0, 0, 0, 0, 1, 0, 32'h0050_0040, 0, 3);
        step(0, 0, 0, 0, 0, 0, 1, 0, 32'h0050_0030, 0, 2);
        step(0, 0, 0, 0, 0, 0, 1, 0, 32'h0050_0020, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 0, 32'h0050_0010, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 32'h0050_0014, 0, 0);

        // Same-cycle push and pop returns old top; the pushed address becomes the new top.
        step(0, 0, 0, 0, 1, 32'h0040_0040, 0, 0, 32'h0050_0018, 0, 1);
        step(0, 0, 0, 0, 1, 32'h0040_0080, 1, 0, 32'h0040_0040, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 0, 32'h0040_0080, 0, 0);

        // Redirect beats a return but the pop still happens; pop on empty with stall holds.
        step(0, 0, 0, 0, 1, 32'h0060_0000, 0, 0, 32'h0040_0084, 0, 1);
        step(0, 0, 1, 32'h0040_0300, 0, 0, 1, 0, 32'h0040_0300, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 32'h0040_0300, 0, 0);

        // Sequential increment wraps modulo 2^32.
        step(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 0);

        // Stall for three cycles with one RAS entry, then reset asynchronously mid-stall.
        step(0, 0, 1, 32'h0040_0010, 1, 32'h0070_0000, 0, 0, 32'h0040_0010, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0040_0010, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0040_0010, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0040_0010, 0, 1);
        @(posedge clock);
        #7;
        check("queue_drained_before_reset", 64'(exp_q.size()), 64'd0);
        reset = 1'b0;
        #1;
        check("async_rst_fetch_pc", 64'(fetch_pc), 64'(RV));
        check("async_rst_fetch_valid", 64'(fetch_valid), 64'd0);
        check("async_rst_ras_count", 64'(ras_count), 64'd0);

        @(posedge clock); #1;
        stall = 1'b0;
        reset = 1'b1;
        exp_q.push_back('{pc: RV, mis: 1'b0, cnt: 3'd0});
        // A return right after reset must fall through: the stack was discarded.
        step(0, 0, 0, 0, 0, 0, 1, 0, 32'h0040_0004, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0008, 0, 0);

        @(posedge clock);
        #7;
        check("queue_drained_at_end", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
